// File: rtl/cdc_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdc_fifo_push_arbiter
// Purpose  : Round-robin arbiter sharing the source-domain push port of a CDC
//            FIFO between NumReq requesters. Winning words are tagged with the
//            requester index ({id, payload}). A burst lock keeps multi-word
//            messages contiguous, and a one-entry output register isolates
//            the arbitration path from FifoFull_DA.
// Ports    : clk_DA      - source-domain clock (rising edge)
//            rst         - synchronous active-high reset
//            Req_DA      - per-requester word valid
//            Last_DA     - per-requester end-of-message flag
//            Data_DA     - packed payloads, requester i at [i*DataWidth +: DataWidth]
//            Grant_DA    - one-hot combinational grant (word consumed this edge)
//            FifoFull_DA - FIFO full, push ignored while high
//            Push_DA     - FIFO push (output register valid)
//            DataIn_DA   - FIFO write data {id, payload}
//            Busy_DA     - high while a burst is locked
//            Owner_DA    - current / last burst owner
// Revision : 1.0 - initial release
// ============================================================================
module cdc_fifo_push_arbiter #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 32,
    parameter int MaxBurst  = 4,
    localparam int IdWidth  = (NumReq == 1) ? 1 : $clog2(NumReq)
) (
    input  logic                          clk_DA,
    input  logic                          rst,
    input  logic [NumReq-1:0]             Req_DA,
    input  logic [NumReq-1:0]             Last_DA,
    input  logic [NumReq*DataWidth-1:0]   Data_DA,
    output logic [NumReq-1:0]             Grant_DA,
    input  logic                          FifoFull_DA,
    output logic                          Push_DA,
    output logic [IdWidth+DataWidth-1:0]  DataIn_DA,
    output logic                          Busy_DA,
    output logic [IdWidth-1:0]            Owner_DA
);

    // Beat counter only needs to reach MaxBurst-1.
    localparam int CntWidth = (MaxBurst < 2) ? 1 : $clog2(MaxBurst);
    // Request/last vectors padded to a power of two so an IdWidth-bit index
    // always addresses a full-width vector.
    localparam int PadReq   = 1 << IdWidth;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]                 r_state;
    logic [0:0]                 w_state_nxt;
    logic                       r_out_valid;
    logic [IdWidth+DataWidth-1:0] r_out_data;
    logic [IdWidth-1:0]         r_rr_ptr;
    logic [IdWidth-1:0]         r_owner;
    logic [CntWidth-1:0]        r_beat_cnt;

    logic [2*NumReq-1:0]        w_req_dbl;
    logic [NumReq-1:0]          w_req_rot;
    logic                       w_rot_any;
    logic [IdWidth-1:0]         w_rot_off;
    logic [IdWidth:0]           w_sum;
    logic [IdWidth-1:0]         w_winner;
    logic [PadReq-1:0]          w_req_pad;
    logic [PadReq-1:0]          w_last_pad;
    logic [IdWidth-1:0]         w_gnt_id;
    logic                       w_slot_free;
    logic                       w_cand;
    logic                       w_gnt_valid;
    logic                       w_gnt_last;
    logic [DataWidth-1:0]       w_gnt_data;
    logic                       w_burst_end;

    function automatic logic [IdWidth-1:0] f_next_ptr(input logic [IdWidth-1:0] id);
        if (id == IdWidth'(NumReq - 1)) begin
            return '0;
        end
        return id + IdWidth'(1);
    endfunction

    // ------------------------------------------------------------------
    // Round-robin search: rotate the request vector so that RrPtr sits at
    // bit 0, pick the lowest set bit, then rotate the offset back.
    // ------------------------------------------------------------------
    assign w_req_dbl = {Req_DA, Req_DA};
    assign w_req_rot = NumReq'(w_req_dbl >> r_rr_ptr);

    always_comb begin
        w_rot_any = 1'b0;
        w_rot_off = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_rot_any = 1'b1;
                w_rot_off = IdWidth'(k);
            end
        end
    end

    assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_rot_off};
    assign w_winner = (w_sum >= (IdWidth+1)'(NumReq)) ?
                      IdWidth'(w_sum - (IdWidth+1)'(NumReq)) : IdWidth'(w_sum);

    assign w_req_pad  = PadReq'(Req_DA);
    assign w_last_pad = PadReq'(Last_DA);

    // In LOCK only the owner is eligible, even if it is momentarily idle.
    assign w_gnt_id    = (r_state == ST_LOCK) ? r_owner : w_winner;
    assign w_slot_free = !r_out_valid || !FifoFull_DA;
    assign w_cand      = (r_state == ST_LOCK) ? w_req_pad[r_owner] : w_rot_any;
    assign w_gnt_valid = !rst && w_slot_free && w_cand;
    assign w_gnt_last  = w_last_pad[w_gnt_id];

    always_comb begin
        w_gnt_data = Data_DA[int'(w_gnt_id)*DataWidth +: DataWidth];
    end

    // A grant closes the burst on Last or when this is the MaxBurst-th beat.
    assign w_burst_end = (r_state == ST_LOCK) ?
                         (w_gnt_last || (r_beat_cnt == CntWidth'(MaxBurst - 1))) :
                         (w_gnt_last || (MaxBurst == 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_DA) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (w_gnt_valid) begin
            w_state_nxt = w_burst_end ? ST_IDLE : ST_LOCK;
        end
    end

    // FSM: outputs
    always_comb begin
        Grant_DA = '0;
        if (w_gnt_valid) begin
            Grant_DA = NumReq'(PadReq'(1) << w_gnt_id);
        end
        Busy_DA = (r_state == ST_LOCK);
    end

    // ------------------------------------------------------------------
    // Output register, round-robin pointer, owner and beat counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_DA) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (w_gnt_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= {w_gnt_id, w_gnt_data};
            end else if (r_out_valid && !FifoFull_DA) begin
                r_out_valid <= 1'b0;
            end

            if (w_gnt_valid) begin
                if (w_burst_end) begin
                    r_rr_ptr   <= f_next_ptr(w_gnt_id);
                    r_beat_cnt <= '0;
                end else if (r_state == ST_IDLE) begin
                    r_owner    <= w_gnt_id;
                    r_beat_cnt <= CntWidth'(1);
                end else begin
                    r_beat_cnt <= r_beat_cnt + CntWidth'(1);
                end
            end
        end
    end

    assign Push_DA   = r_out_valid;
    assign DataIn_DA = r_out_data;
    assign Owner_DA  = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_cdc_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_fifo_push_arbiter
// Purpose  : Self-checking bench for cdc_fifo_push_arbiter. Per-requester
//            message queues feed the DUT; expected {id, payload} words are
//            queued on a scoreboard and compared when the FIFO accepts them.
//            A second instance covers the NumReq=1 / MaxBurst=1 corner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_fifo_push_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   Req_DA = '0;
    logic [3:0]   Last_DA = '0;
    logic [127:0] Data_DA = '0;
    logic [3:0]   Grant_DA;
    logic         FifoFull_DA = 1'b0;
    logic         Push_DA;
    logic [33:0]  DataIn_DA;
    logic         Busy_DA;
    logic [1:0]   Owner_DA;

    logic [0:0]   r1_req = '0;
    logic [0:0]   r1_last = '0;
    logic [31:0]  r1_data = '0;
    logic [0:0]   w1_gnt;
    logic         r1_full = 1'b0;
    logic         w1_push;
    logic [32:0]  w1_din;
    logic         w1_busy;
    logic [0:0]   w1_owner;

    always #5 clk = ~clk;

    cdc_fifo_push_arbiter #(.NumReq(4), .DataWidth(32), .MaxBurst(4)) u_dut (
        .clk_DA(clk), .rst(rst), .Req_DA(Req_DA), .Last_DA(Last_DA),
        .Data_DA(Data_DA), .Grant_DA(Grant_DA), .FifoFull_DA(FifoFull_DA),
        .Push_DA(Push_DA), .DataIn_DA(DataIn_DA), .Busy_DA(Busy_DA),
        .Owner_DA(Owner_DA)
    );

    cdc_fifo_push_arbiter #(.NumReq(1), .DataWidth(32), .MaxBurst(1)) u_dut1 (
        .clk_DA(clk), .rst(rst), .Req_DA(r1_req), .Last_DA(r1_last),
        .Data_DA(r1_data), .Grant_DA(w1_gnt), .FifoFull_DA(r1_full),
        .Push_DA(w1_push), .DataIn_DA(w1_din), .Busy_DA(w1_busy),
        .Owner_DA(w1_owner)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    logic [32:0] q_msg [4][$];
    logic [33:0] sb [$];
    logic [3:0]  hold = '0;
    logic        tb_full = 1'b0;
    logic        tb_rst = 1'b1;
    int          cyc = 0;
    int          n_push = 0;
    int          first_push_cyc = -1;
    int          last_push_cyc = -1;
    int          first_gnt_cyc = -1;
    logic [15:0] busy_log = '0;

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic load(input int r, input logic last, input logic [31:0] d);
        q_msg[r].push_back({last, d});
    endtask

    task automatic expect_word(input int id, input logic [31:0] d);
        logic [1:0] w_id;
        w_id = id[1:0];
        sb.push_back({w_id, d});
    endtask

    // One clock: drive at the falling edge, sample just before the rising edge.
    task automatic tick();
        logic [33:0] exp;
        @(negedge clk);
        rst = tb_rst;
        FifoFull_DA = tb_full;
        for (int i = 0; i < 4; i++) begin
            if (q_msg[i].size() > 0 && !hold[i]) begin
                Req_DA[i]          = 1'b1;
                Last_DA[i]         = q_msg[i][0][32];
                Data_DA[i*32 +: 32] = q_msg[i][0][31:0];
            end else begin
                Req_DA[i]          = 1'b0;
                Last_DA[i]         = 1'b0;
                Data_DA[i*32 +: 32] = '0;
            end
        end
        #4;
        cyc++;
        busy_log = {busy_log[14:0], Busy_DA};
        if (Push_DA && !FifoFull_DA && !rst) begin
            n_push++;
            if (first_push_cyc < 0) first_push_cyc = cyc;
            last_push_cyc = cyc;
            if (sb.size() == 0) begin
                chk_val("push_unexpected", {63'd0, Push_DA}, 64'd0);
            end else begin
                exp = sb.pop_front();
                chk_val("push_word", {30'd0, DataIn_DA}, {30'd0, exp});
            end
        end
        if (Grant_DA != 4'b0 && first_gnt_cyc < 0) first_gnt_cyc = cyc;
        for (int i = 0; i < 4; i++) begin
            if (Grant_DA[i]) begin
                if (q_msg[i].size() > 0) void'(q_msg[i].pop_front());
                else chk_val("grant_no_req", {60'd0, Grant_DA}, 64'd0);
            end
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) q_msg[i].delete();
        sb.delete();
        hold = '0;
        tb_full = 1'b0;
        n_push = 0;
        first_push_cyc = -1;
        last_push_cyc = -1;
        first_gnt_cyc = -1;
    endtask

    task automatic do_reset();
        clear_all();
        tb_rst = 1'b1;
        tick();
        tb_rst = 1'b0;
    endtask

    task automatic run_until_empty(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() > 0) chk_val("sb_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        tick();
        chk_val("rst_push",  {63'd0, Push_DA}, 64'd0);
        chk_val("rst_data",  {30'd0, DataIn_DA}, 64'd0);
        chk_val("rst_grant", {60'd0, Grant_DA}, 64'd0);
        chk_val("rst_busy",  {63'd0, Busy_DA}, 64'd0);
        chk_val("rst_owner", {62'd0, Owner_DA}, 64'd0);

        // ---------------- alternating singles 0/2 ----------------
        do_reset();
        for (int k = 0; k < 8; k++) begin
            load(0, 1'b1, 32'h100 + k);
            load(2, 1'b1, 32'h200 + k);
            expect_word(0, 32'h100 + k);
            expect_word(2, 32'h200 + k);
        end
        run_until_empty(40);
        chk_val("alt_latency", 64'(first_push_cyc - first_gnt_cyc), 64'd1);
        chk_val("alt_count",   64'(n_push), 64'd16);
        chk_val("alt_rate",    64'(last_push_cyc - first_push_cyc), 64'd15);

        // ---------------- burst cut at MaxBurst ----------------
        do_reset();
        for (int k = 0; k < 6; k++) load(1, (k == 5), 32'h1000 + k);
        load(3, 1'b1, 32'h3000);
        for (int k = 0; k < 4; k++) expect_word(1, 32'h1000 + k);
        expect_word(3, 32'h3000);
        expect_word(1, 32'h1004);
        expect_word(1, 32'h1005);
        for (int k = 0; k < 7; k++) tick();
        chk_val("burst_busy_seq", {57'd0, busy_log[6:0]}, 64'b0111001);
        chk_val("burst_owner",    {62'd0, Owner_DA}, 64'd1);
        run_until_empty(20);

        // ---------------- FIFO full hold ----------------
        do_reset();
        load(0, 1'b1, 32'hA5A5A5A5);
        expect_word(0, 32'hA5A5A5A5);
        expect_word(1, 32'h11);
        tick();
        load(1, 1'b1, 32'h11);
        tb_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_val("full_push",  {63'd0, Push_DA}, 64'd1);
            chk_val("full_data",  {30'd0, DataIn_DA}, 64'h0A5A5A5A5);
            chk_val("full_grant", {60'd0, Grant_DA}, 64'd0);
        end
        tb_full = 1'b0;
        tick();
        chk_val("full_release_pushes", 64'(n_push), 64'd1);
        chk_val("full_release_grant",  {60'd0, Grant_DA}, 64'b0010);
        run_until_empty(10);

        // ---------------- owner stalls mid-burst ----------------
        do_reset();
        for (int k = 0; k < 4; k++) begin
            load(2, (k == 3), 32'h20 + k);
            expect_word(2, 32'h20 + k);
        end
        expect_word(0, 32'h05);
        tick();
        hold[2] = 1'b1;
        load(0, 1'b1, 32'h05);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_val("stall_grant", {60'd0, Grant_DA}, 64'd0);
            chk_val("stall_busy",  {63'd0, Busy_DA}, 64'd1);
        end
        hold[2] = 1'b0;
        tick();
        chk_val("stall_resume", {60'd0, Grant_DA}, 64'b0100);
        run_until_empty(20);

        // ---------------- reset during a locked burst ----------------
        do_reset();
        load(1, 1'b0, 32'h50);
        load(1, 1'b0, 32'h51);
        load(1, 1'b0, 32'h52);
        expect_word(1, 32'h50);
        tick();
        tick();
        chk_val("pre_rst_busy", {63'd0, Busy_DA}, 64'd1);
        chk_val("pre_rst_push", {63'd0, Push_DA}, 64'd1);
        tb_rst = 1'b1;
        tick();
        chk_val("in_rst_grant", {60'd0, Grant_DA}, 64'd0);
        chk_val("in_rst_sb_left", 64'(sb.size()), 64'd0);
        tb_rst = 1'b0;
        q_msg[1].delete();
        load(3, 1'b1, 32'h33);
        load(2, 1'b1, 32'h22);
        expect_word(2, 32'h22);
        expect_word(3, 32'h33);
        tick();
        chk_val("post_rst_push",  {63'd0, Push_DA}, 64'd0);
        chk_val("post_rst_busy",  {63'd0, Busy_DA}, 64'd0);
        chk_val("post_rst_grant", {60'd0, Grant_DA}, 64'b0100);
        run_until_empty(10);

        // ---------------- single requester, MaxBurst=1 ----------------
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            r1_req  = 1'b1;
            r1_last = 1'b0;
            r1_data = 32'hC0 + k;
            #4;
            chk_val("n1_grant", {63'd0, w1_gnt}, 64'd1);
            chk_val("n1_busy",  {63'd0, w1_busy}, 64'd0);
            if (k > 0) chk_val("n1_push_word", {30'd0, w1_push, w1_din},
                               {30'd0, 1'b1, 1'b0, 32'hC0 + 32'(k - 1)});
        end
        @(negedge clk);
        r1_req = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
